// File: rtl/binary_trainer_if.sv
// Player-facing signal bundle for binary_trainer.
// The slave side is the game core; the master side is the player/console.
interface binary_trainer_if #(
    parameter int WIDTH   = 8,
    parameter int SCORE_W = 8
);
    logic               Select;
    logic               Quit;
    logic               Mode;
    logic [WIDTH-1:0]   userNumber;
    logic [WIDTH-1:0]   targetNumber;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] highScore;
    logic [3:0]         livesLeft;
    logic [1:0]         stateOut;
    logic               hit;
    logic               miss;

    modport slave (
        input  Select, Quit, Mode, userNumber,
        output targetNumber, score, highScore, livesLeft, stateOut, hit, miss
    );

    modport master (
        output Select, Quit, Mode, userNumber,
        input  targetNumber, score, highScore, livesLeft, stateOut, hit, miss
    );
endinterface

// File: rtl/binary_trainer.sv
// Binary-entry reaction game: match a free-running target, with play (lives) and practice modes.
// Define ROUND_TIMER_EN to add a per-round timeout that acts as a wrong answer.
module binary_trainer #(
    parameter int WIDTH   = 8,
    parameter int LIVES   = 3,
    parameter int SCORE_W = 8,
    parameter int TIMEOUT = 100000000
) (
    input  logic            Clk,
    input  logic            Reset,
    binary_trainer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        ROUND = 2'd2,
        OVER  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   fast_q, fast_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [3:0]         lives_q, lives_d;
    logic               mode_q, mode_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;

    logic in_round, match, timed_out, hit_ev, miss_ev, last_life;

`ifdef ROUND_TIMER_EN
    localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TIMER_W-1:0] timer_q, timer_d;
    assign timed_out = (timer_q == TIMER_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    // Quit outranks Select, and an explicit Select outranks the timeout.
    assign in_round  = (state_q == ROUND);
    assign match     = (bus.userNumber == target_q);
    assign hit_ev    = in_round && !bus.Quit && bus.Select && match;
    assign miss_ev   = in_round && !bus.Quit && (bus.Select ? !match : timed_out);
    assign last_life = mode_q && (lives_q <= 4'd1);

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Select) state_d = DRAW;
            DRAW:    state_d = ROUND;
            ROUND: begin
                if (bus.Quit)                  state_d = OVER;
                else if (hit_ev)               state_d = DRAW;
                else if (miss_ev && last_life) state_d = OVER;
            end
            OVER:    if (bus.Select) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fast_d   = fast_q + WIDTH'(1);
        target_d = target_q;
        score_d  = score_q;
        high_d   = high_q;
        lives_d  = lives_q;
        mode_d   = mode_q;
        hit_d    = hit_ev;
        miss_d   = miss_ev;
        if (state_q == IDLE && bus.Select) begin
            mode_d  = bus.Mode;
            score_d = '0;
            lives_d = 4'(LIVES);
        end
        if (state_q == DRAW) target_d = fast_q;
        if (hit_ev && score_q != '1) score_d = score_q + SCORE_W'(1);
        if (miss_ev && mode_q) lives_d = lives_q - 4'd1;
        // Score is frozen on the leaving edge, so the current value is the final one.
        if (in_round && state_d == OVER && mode_q && score_q > high_q) high_d = score_q;
    end

`ifdef ROUND_TIMER_EN
    always_comb begin
        timer_d = '0;
        if (in_round && state_d == ROUND && !miss_ev) timer_d = timer_q + TIMER_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fast_q   <= '0;
            target_q <= '0;
            score_q  <= '0;
            high_q   <= '0;
            lives_q  <= '0;
            mode_q   <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            fast_q   <= fast_d;
            target_q <= target_d;
            score_q  <= score_d;
            high_q   <= high_d;
            lives_q  <= lives_d;
            mode_q   <= mode_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign bus.targetNumber = target_q;
    assign bus.score        = score_q;
    assign bus.highScore    = high_q;
    assign bus.livesLeft    = lives_q;
    assign bus.stateOut     = state_q;
    assign bus.hit          = hit_q;
    assign bus.miss         = miss_q;
endmodule

// File: doc/binary_trainer.md
BINARY_TRAINER -- requirements
Module: binary_trainer

Interface
REQ-001 Parameter WIDTH, default 8, meaning bit width of target/user numbers (legal 2..16).
REQ-002 Parameter LIVES, default 3, meaning wrong answers allowed per play-mode game (legal 1..15).
REQ-003 Parameter SCORE_W, default 8, meaning width of score/highScore counters.
REQ-004 Parameter TIMEOUT, default 100000000, meaning ROUND cycles before forced miss (used only with ROUND_TIMER_EN).
REQ-005 Clk  in  1  sole clock, all logic on rising edge.
REQ-006 Reset  in  1  synchronous active-high reset.
REQ-007 Select  in  1  single-cycle pulse, start/confirm/acknowledge.
REQ-008 Quit  in  1  single-cycle pulse, abandon current game.
REQ-009 Mode  in  1  1 = play (lives), 0 = practice (unlimited); sampled at game start.
REQ-010 userNumber  in  WIDTH  player's guess.
REQ-011 targetNumber  out  WIDTH  current number to be entered.
REQ-012 score  out  SCORE_W  correct answers this game.
REQ-013 highScore  out  SCORE_W  best play-mode score since reset.
REQ-014 livesLeft  out  4  remaining lives.
REQ-015 stateOut  out  2  IDLE=0, DRAW=1, ROUND=2, OVER=3.
REQ-016 hit  out  1  one-cycle pulse, correct answer accepted.
REQ-017 miss  out  1  one-cycle pulse, wrong answer or timeout.

Function
REQ-018 fastCount (WIDTH bits) increments every cycle outside reset, wraps 2^WIDTH-1 -> 0.
REQ-019 IDLE: Select -> DRAW; latch Mode into modeReg; score <= 0; livesLeft <= LIVES.
REQ-020 DRAW (exactly one cycle): targetNumber <= fastCount value of that cycle; -> ROUND.
REQ-021 ROUND, priority Quit > Select > timeout.
REQ-022 ROUND Quit -> OVER; no hit/miss.
REQ-023 ROUND Select with userNumber == targetNumber: hit=1, score+1 saturating at 2^SCORE_W-1, -> DRAW.
REQ-024 ROUND Select with mismatch: miss=1; play mode livesLeft-1, -> OVER when it reaches 0, else stay ROUND with same target; practice mode livesLeft unchanged, stay ROUND.
REQ-025 OVER entry (transition cycle): if modeReg=1 and score > highScore, highScore <= score; equal score leaves highScore unchanged.
REQ-026 OVER: Select -> IDLE; score, targetNumber, livesLeft held until next game start.
REQ-027 Select and Quit in IDLE/OVER: Quit ignored in IDLE; Select wins in OVER.
REQ-028 Inputs in DRAW ignored; hit and miss never asserted together.
REQ-029 Unreachable stateOut encoding recovers to IDLE next cycle.

Reset
REQ-030 Reset has priority over all inputs; next state IDLE.
REQ-031 Reset values: fastCount=0, targetNumber=0, score=0, highScore=0, livesLeft=0, modeReg=0, hit=0, miss=0, timer=0.
REQ-032 Reset mid-game clears highScore; no OVER update occurs.

Configuration
REQ-033 Macro ROUND_TIMER_EN defined: timer counts ROUND cycles, cleared on entering ROUND and on each miss; at TIMEOUT-1 with no Select/Quit, behave as mismatched Select (REQ-024); Select same cycle wins.
REQ-034 Macro ROUND_TIMER_EN undefined: no timer logic; ROUND waits indefinitely; TIMEOUT ignored.

Verification (WIDTH=4, LIVES=2, SCORE_W=4, TIMEOUT=16)
REQ-035 Reset, Select at cycle 5, Mode=1 -> DRAW cycle 6, targetNumber=6, stateOut=2 at cycle 7.
REQ-036 Play, two mismatched Selects -> miss pulses, livesLeft 2->1->0, stateOut=3, highScore unchanged at 0.
REQ-037 Play, 3 correct then Quit -> score=3, OVER, highScore=3; next game 2 correct then Quit -> highScore stays 3.
REQ-038 Practice, 5 mismatches -> livesLeft stays 2, still ROUND; Quit -> OVER, highScore unchanged.
REQ-039 Select and Quit same ROUND cycle -> OVER, hit=0, score unchanged; score 15 plus correct -> stays 15.
REQ-040 ROUND_TIMER_EN, play, no input 16 cycles -> miss, livesLeft=1; Select at timeout cycle with correct value -> hit, no miss.
